// File: rtl/snn_inference_ctrl.sv
// snn_inference_ctrl
//
// Inference sequencer between the AXI4-Lite register file and the SNN core.
// A NEW_IMAGE level from the host starts one inference. The stored image is
// streamed pixel by pixel into the core over a valid/ready handshake, the
// core is kicked with a one-cycle start pulse, and the block then waits for
// the core's done pulse. The inferred digit is latched and the ready status
// is raised for the host to poll.
//
// Optional feature (compile-time macro SNN_CTRL_TIMEOUT_EN):
//   When defined, a RUN-cycle counter aborts an inference that runs longer
//   than TIMEOUT_CYCLES. The result is then 8'hFF and TIMEOUT is set.
//   When undefined, no counter is built, TIMEOUT is tied low and RUN waits
//   indefinitely for CORE_DONE.
//
// Parameters:
//   IMAGE_SIZE      pixels per image
//   PIXEL_BITS      bits per pixel
//   TIMEOUT_CYCLES  maximum RUN cycles before abort (timeout build only)
//
// Ports:
//   ACLK              clock
//   ARESETN           synchronous active-low reset
//   NEW_IMAGE         register-file flag: image loaded, start inference
//   PIXEL_ADDR        pixel index into the register-file image array
//   IMAGE_PIXEL       pixel at PIXEL_ADDR (combinational read)
//   CORE_PIXEL_VALID  pixel stream valid
//   CORE_PIXEL_DATA   pixel stream data (pass-through of IMAGE_PIXEL)
//   CORE_PIXEL_READY  core accepts pixel
//   CORE_START        one-cycle start pulse to the core
//   CORE_DONE         core inference complete (one-cycle pulse)
//   CORE_DIGIT        core result, valid with CORE_DONE
//   COPROCESSOR_RDY   idle or result available
//   INFERED_DIGIT     latched result
//   TIMEOUT           last inference aborted by timeout

module snn_inference_ctrl #(
  parameter int IMAGE_SIZE     = 256,
  parameter int PIXEL_BITS     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          NEW_IMAGE,
  output logic [$clog2(IMAGE_SIZE)-1:0] PIXEL_ADDR,
  input  logic [PIXEL_BITS-1:0]         IMAGE_PIXEL,
  output logic                          CORE_PIXEL_VALID,
  output logic [PIXEL_BITS-1:0]         CORE_PIXEL_DATA,
  input  logic                          CORE_PIXEL_READY,
  output logic                          CORE_START,
  input  logic                          CORE_DONE,
  input  logic [7:0]                    CORE_DIGIT,
  output logic                          COPROCESSOR_RDY,
  output logic [7:0]                    INFERED_DIGIT,
  output logic                          TIMEOUT
);

  localparam int AW = $clog2(IMAGE_SIZE);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMAGE_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic transfer;
  logic run_done;
  logic expire;

  assign transfer = CORE_PIXEL_VALID && CORE_PIXEL_READY;
  // CORE_DONE only counts while RUN; stray pulses elsewhere are dropped.
  assign run_done = (state == RUN) && CORE_DONE;

  assign CORE_PIXEL_DATA = IMAGE_PIXEL;

`ifdef SNN_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] run_cnt;
  logic          timeout_q;

  // Held at zero outside RUN, so it is already clear on RUN entry.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      run_cnt <= '0;
    end else if (state != RUN) begin
      run_cnt <= '0;
    end else if (!CORE_DONE) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  // A done arriving in the expiry cycle takes priority over the abort.
  assign expire = (state == RUN) && !CORE_DONE && (run_cnt == RUN_LAST);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      timeout_q <= 1'b0;
    end else if ((state == IDLE) && NEW_IMAGE) begin
      timeout_q <= 1'b0;
    end else if (expire) begin
      timeout_q <= 1'b1;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign expire  = 1'b0;
  assign TIMEOUT = 1'b0;
`endif

  // Next-state logic. DONE waits for NEW_IMAGE to drop so that a level
  // left high by the host triggers exactly one inference.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (NEW_IMAGE) state_next = LOAD;
      LOAD:    if (transfer && (PIXEL_ADDR == LAST_ADDR)) state_next = START;
      START:   state_next = RUN;
      RUN:     if (run_done || expire) state_next = DONE;
      DONE:    if (!NEW_IMAGE) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register. The handshake/status outputs are decoded from the next
  // state so they are registered yet line up with the state they describe.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state            <= IDLE;
      CORE_PIXEL_VALID <= 1'b0;
      CORE_START       <= 1'b0;
      COPROCESSOR_RDY  <= 1'b1;
    end else begin
      state            <= state_next;
      CORE_PIXEL_VALID <= (state_next == LOAD);
      CORE_START       <= (state_next == START);
      COPROCESSOR_RDY  <= (state_next == IDLE) || (state_next == DONE);
    end
  end

  // Pixel address saturates at the last pixel; it is cleared when the next
  // inference is accepted rather than wrapping.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      PIXEL_ADDR    <= '0;
      INFERED_DIGIT <= 8'h00;
    end else begin
      if ((state == IDLE) && NEW_IMAGE) begin
        PIXEL_ADDR <= '0;
      end else if (transfer && (PIXEL_ADDR != LAST_ADDR)) begin
        PIXEL_ADDR <= PIXEL_ADDR + 1'b1;
      end

      if (run_done) begin
        INFERED_DIGIT <= CORE_DIGIT;
      end else if (expire) begin
        INFERED_DIGIT <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// tb_snn_inference_ctrl
//
// Directed self-checking bench for snn_inference_ctrl. A negedge monitor
// records every pixel transfer and start pulse; scenario tasks drive the
// host/core side just after each rising edge and compare outputs against
// hand-derived expectations. Timeout scenarios are compiled in only when
// SNN_CTRL_TIMEOUT_EN is defined (TIMEOUT_CYCLES is then overridden to 16).

module tb_snn_inference_ctrl;

  localparam int IMAGE_SIZE = 256;
  localparam int PIXEL_BITS = 8;
`ifdef SNN_CTRL_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = 16;
`else
  localparam int TIMEOUT_CYCLES = 65535;
`endif
  localparam int RUN_WAIT = (TIMEOUT_CYCLES > 40) ? 30 : 3;

  logic                  ACLK = 1'b0;
  logic                  ARESETN = 1'b0;
  logic                  NEW_IMAGE = 1'b0;
  logic [7:0]            PIXEL_ADDR;
  logic [PIXEL_BITS-1:0] IMAGE_PIXEL;
  logic                  CORE_PIXEL_VALID;
  logic [PIXEL_BITS-1:0] CORE_PIXEL_DATA;
  logic                  CORE_PIXEL_READY = 1'b1;
  logic                  CORE_START;
  logic                  CORE_DONE = 1'b0;
  logic [7:0]            CORE_DIGIT = 8'h00;
  logic                  COPROCESSOR_RDY;
  logic [7:0]            INFERED_DIGIT;
  logic                  TIMEOUT;

  logic [7:0] image_mem [0:IMAGE_SIZE-1];

  int checks = 0;
  int fails  = 0;

  snn_inference_ctrl #(
    .IMAGE_SIZE    (IMAGE_SIZE),
    .PIXEL_BITS    (PIXEL_BITS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .NEW_IMAGE       (NEW_IMAGE),
    .PIXEL_ADDR      (PIXEL_ADDR),
    .IMAGE_PIXEL     (IMAGE_PIXEL),
    .CORE_PIXEL_VALID(CORE_PIXEL_VALID),
    .CORE_PIXEL_DATA (CORE_PIXEL_DATA),
    .CORE_PIXEL_READY(CORE_PIXEL_READY),
    .CORE_START      (CORE_START),
    .CORE_DONE       (CORE_DONE),
    .CORE_DIGIT      (CORE_DIGIT),
    .COPROCESSOR_RDY (COPROCESSOR_RDY),
    .INFERED_DIGIT   (INFERED_DIGIT),
    .TIMEOUT         (TIMEOUT)
  );

  assign IMAGE_PIXEL = image_mem[PIXEL_ADDR];

  always #5 ACLK = ~ACLK;

  // Monitor: transfers, start pulses and stall stability, sampled at negedge.
  logic [7:0] xfer_data [$];
  logic [7:0] xfer_addr [$];
  int         start_cnt = 0;
  int         stall_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  logic [7:0] prev_data = 8'h00;

  always @(negedge ACLK) begin
    if (CORE_START === 1'b1) start_cnt++;
    if (prev_stall && ((PIXEL_ADDR !== prev_addr) || (CORE_PIXEL_DATA !== prev_data)))
      stall_err++;
    prev_stall = CORE_PIXEL_VALID && !CORE_PIXEL_READY;
    prev_addr  = PIXEL_ADDR;
    prev_data  = CORE_PIXEL_DATA;
    if (CORE_PIXEL_VALID === 1'b1 && CORE_PIXEL_READY === 1'b1) begin
      xfer_data.push_back(CORE_PIXEL_DATA);
      xfer_addr.push_back(PIXEL_ADDR);
    end
  end

  function automatic logic [7:0] pat(input int mode, input int i);
    logic [7:0] v;
    v = i[7:0];
    case (mode)
      1:       pat = v ^ 8'hA5;
      2:       pat = 8'd255 - v;
      default: pat = v;
    endcase
  endfunction

  task automatic load_image(input int mode);
    for (int i = 0; i < IMAGE_SIZE; i++) image_mem[i] = pat(mode, i);
  endtask

  task automatic clear_mon();
    xfer_data.delete();
    xfer_addr.delete();
    start_cnt  = 0;
    stall_err  = 0;
    prev_stall = 1'b0;
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Advance until CORE_START is seen or the budget expires.
  task automatic wait_start(input int budget, input bit rand_ready,
                            output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget) begin
      step();
      n++;
      if (rand_ready) CORE_PIXEL_READY = 1'($urandom_range(0, 1));
      if (CORE_START === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    CORE_PIXEL_READY = 1'b1;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    NEW_IMAGE = 1'b0;
    step();
    step();
    ARESETN = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      checks++;
      if (COPROCESSOR_RDY !== 1'b1 || INFERED_DIGIT !== 8'h00 || CORE_PIXEL_VALID !== 1'b0 ||
          CORE_START !== 1'b0 || TIMEOUT !== 1'b0 || PIXEL_ADDR !== 8'h00) begin
        fails++;
        $display("[TB] FAIL reset_idle cycle %0d: rdy=%b digit=%h valid=%b start=%b to=%b addr=%0d, required 1/00/0/0/0/0",
                 c, COPROCESSOR_RDY, INFERED_DIGIT, CORE_PIXEL_VALID, CORE_START, TIMEOUT, PIXEL_ADDR);
      end
    end
  endtask

  task automatic test_basic();
    int n;
    bit ok;
    load_image(0);
    clear_mon();
    CORE_PIXEL_READY = 1'b1;
    NEW_IMAGE = 1'b1;
    step();
    checks++;
    if (CORE_PIXEL_VALID !== 1'b1 || PIXEL_ADDR !== 8'd0 || COPROCESSOR_RDY !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_load_entry: valid=%b addr=%0d rdy=%b, required 1/0/0",
               CORE_PIXEL_VALID, PIXEL_ADDR, COPROCESSOR_RDY);
    end
    wait_start(400, 1'b0, n, ok);
    checks++;
    if (!ok || n != IMAGE_SIZE) begin
      fails++;
      $display("[TB] FAIL basic_start_latency: seen=%0d after %0d cycles, required start after %0d",
               ok, n, IMAGE_SIZE);
    end
    for (int c = 0; c < 5; c++) step();
    CORE_DONE  = 1'b1;
    CORE_DIGIT = 8'd7;
    checks++;
    if (COPROCESSOR_RDY !== 1'b0 || INFERED_DIGIT !== 8'h00) begin
      fails++;
      $display("[TB] FAIL basic_run_wait: rdy=%b digit=%h, required 0/00", COPROCESSOR_RDY, INFERED_DIGIT);
    end
    step();
    CORE_DONE  = 1'b0;
    CORE_DIGIT = 8'h00;
    checks++;
    if (COPROCESSOR_RDY !== 1'b1 || INFERED_DIGIT !== 8'd7 || TIMEOUT !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_result: rdy=%b digit=%h to=%b, required 1/07/0",
               COPROCESSOR_RDY, INFERED_DIGIT, TIMEOUT);
    end
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (COPROCESSOR_RDY !== 1'b1 || CORE_PIXEL_VALID !== 1'b0 || INFERED_DIGIT !== 8'd7) begin
        fails++;
        $display("[TB] FAIL basic_done_hold cycle %0d: rdy=%b valid=%b digit=%h, required 1/0/07",
                 c, COPROCESSOR_RDY, CORE_PIXEL_VALID, INFERED_DIGIT);
      end
    end
    checks++;
    if (start_cnt != 1 || xfer_data.size() != IMAGE_SIZE) begin
      fails++;
      $display("[TB] FAIL basic_counts: starts=%0d transfers=%0d, required 1/%0d",
               start_cnt, xfer_data.size(), IMAGE_SIZE);
    end
    for (int i = 0; i < xfer_data.size(); i++) begin
      checks++;
      if (xfer_data[i] !== pat(0, i) || xfer_addr[i] !== 8'(i)) begin
        fails++;
        $display("[TB] FAIL basic_data[%0d]: data=%h addr=%0d, required %h/%0d",
                 i, xfer_data[i], xfer_addr[i], pat(0, i), i);
        break;
      end
    end
    NEW_IMAGE = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (COPROCESSOR_RDY !== 1'b1 || CORE_PIXEL_VALID !== 1'b0 || start_cnt != 1) begin
        fails++;
        $display("[TB] FAIL basic_idle_return: rdy=%b valid=%b starts=%0d, required 1/0/1",
                 COPROCESSOR_RDY, CORE_PIXEL_VALID, start_cnt);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit ok;
    load_image(1);
    clear_mon();
    NEW_IMAGE = 1'b1;
    CORE_PIXEL_READY = 1'($urandom_range(0, 1));
    step();
    CORE_PIXEL_READY = 1'($urandom_range(0, 1));
    wait_start(3000, 1'b1, n, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL bp_start: start not seen within %0d cycles, required start", n);
    end
    step();
    CORE_DONE  = 1'b1;
    CORE_DIGIT = 8'd3;
    step();
    CORE_DONE  = 1'b0;
    CORE_DIGIT = 8'h00;
    checks++;
    if (COPROCESSOR_RDY !== 1'b1 || INFERED_DIGIT !== 8'd3) begin
      fails++;
      $display("[TB] FAIL bp_result: rdy=%b digit=%h, required 1/03", COPROCESSOR_RDY, INFERED_DIGIT);
    end
    checks++;
    if (xfer_data.size() != IMAGE_SIZE || stall_err != 0 || start_cnt != 1) begin
      fails++;
      $display("[TB] FAIL bp_counts: transfers=%0d stall_errors=%0d starts=%0d, required %0d/0/1",
               xfer_data.size(), stall_err, start_cnt, IMAGE_SIZE);
    end
    for (int i = 0; i < xfer_data.size(); i++) begin
      checks++;
      if (xfer_data[i] !== pat(1, i) || xfer_addr[i] !== 8'(i)) begin
        fails++;
        $display("[TB] FAIL bp_data[%0d]: data=%h addr=%0d, required %h/%0d",
                 i, xfer_data[i], xfer_addr[i], pat(1, i), i);
        break;
      end
    end
    NEW_IMAGE = 1'b0;
    step();
    step();
  endtask

  task automatic test_drop_and_spurious();
    int n;
    bit ok;
    load_image(2);
    clear_mon();
    NEW_IMAGE = 1'b1;
    step();
    for (int c = 0; c < 50; c++) step();
    NEW_IMAGE = 1'b0;
    for (int c = 0; c < 49; c++) step();
    CORE_DONE  = 1'b1;
    CORE_DIGIT = 8'd9;
    step();
    CORE_DONE  = 1'b0;
    CORE_DIGIT = 8'h00;
    step();
    checks++;
    if (INFERED_DIGIT !== 8'd3 || COPROCESSOR_RDY !== 1'b0 || CORE_PIXEL_VALID !== 1'b1) begin
      fails++;
      $display("[TB] FAIL spurious_done_ignored: digit=%h rdy=%b valid=%b, required 03/0/1",
               INFERED_DIGIT, COPROCESSOR_RDY, CORE_PIXEL_VALID);
    end
    wait_start(400, 1'b0, n, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL drop_start: start not seen within %0d cycles, required start", n);
    end
    for (int c = 0; c < RUN_WAIT; c++) step();
    checks++;
    if (COPROCESSOR_RDY !== 1'b0 || INFERED_DIGIT !== 8'd3) begin
      fails++;
      $display("[TB] FAIL drop_run_wait: rdy=%b digit=%h, required 0/03", COPROCESSOR_RDY, INFERED_DIGIT);
    end
    CORE_DONE  = 1'b1;
    CORE_DIGIT = 8'h42;
    step();
    CORE_DONE  = 1'b0;
    CORE_DIGIT = 8'h00;
    checks++;
    if (COPROCESSOR_RDY !== 1'b1 || INFERED_DIGIT !== 8'h42) begin
      fails++;
      $display("[TB] FAIL drop_result: rdy=%b digit=%h, required 1/42", COPROCESSOR_RDY, INFERED_DIGIT);
    end
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (xfer_data.size() != IMAGE_SIZE || start_cnt != 1 || CORE_PIXEL_VALID !== 1'b0 ||
        COPROCESSOR_RDY !== 1'b1) begin
      fails++;
      $display("[TB] FAIL drop_counts: transfers=%0d starts=%0d valid=%b rdy=%b, required %0d/1/0/1",
               xfer_data.size(), start_cnt, CORE_PIXEL_VALID, COPROCESSOR_RDY, IMAGE_SIZE);
    end
    for (int i = 0; i < xfer_data.size(); i++) begin
      checks++;
      if (xfer_data[i] !== pat(2, i)) begin
        fails++;
        $display("[TB] FAIL drop_data[%0d]: data=%h, required %h", i, xfer_data[i], pat(2, i));
        break;
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int n;
    bit ok;
    load_image(0);
    clear_mon();
    NEW_IMAGE = 1'b1;
    step();
    n = 0;
    while (PIXEL_ADDR !== 8'd100 && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (PIXEL_ADDR !== 8'd100) begin
      fails++;
      $display("[TB] FAIL rst_reach_100: addr=%0d, required 100", PIXEL_ADDR);
    end
    ARESETN = 1'b0;
    NEW_IMAGE = 1'b0;
    step();
    checks++;
    if (PIXEL_ADDR !== 8'd0 || CORE_PIXEL_VALID !== 1'b0 || CORE_START !== 1'b0 ||
        COPROCESSOR_RDY !== 1'b1 || INFERED_DIGIT !== 8'h00 || TIMEOUT !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_values: addr=%0d valid=%b start=%b rdy=%b digit=%h to=%b, required 0/0/0/1/00/0",
               PIXEL_ADDR, CORE_PIXEL_VALID, CORE_START, COPROCESSOR_RDY, INFERED_DIGIT, TIMEOUT);
    end
    ARESETN = 1'b1;
    step();
    step();
    checks++;
    if (start_cnt != 0 || CORE_PIXEL_VALID !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_no_pulse: starts=%0d valid=%b, required 0/0", start_cnt, CORE_PIXEL_VALID);
    end
    clear_mon();
    NEW_IMAGE = 1'b1;
    step();
    checks++;
    if (CORE_PIXEL_VALID !== 1'b1 || PIXEL_ADDR !== 8'd0) begin
      fails++;
      $display("[TB] FAIL rst_restart: valid=%b addr=%0d, required 1/0", CORE_PIXEL_VALID, PIXEL_ADDR);
    end
    wait_start(400, 1'b0, n, ok);
    checks++;
    if (!ok || n != IMAGE_SIZE || xfer_data.size() != IMAGE_SIZE || xfer_addr[0] !== 8'd0) begin
      fails++;
      $display("[TB] FAIL rst_reload: start=%0d cycles=%0d transfers=%0d, required 1/%0d/%0d from addr 0",
               ok, n, xfer_data.size(), IMAGE_SIZE, IMAGE_SIZE);
    end
    step();
    CORE_DONE  = 1'b1;
    CORE_DIGIT = 8'd5;
    step();
    CORE_DONE  = 1'b0;
    CORE_DIGIT = 8'h00;
    checks++;
    if (COPROCESSOR_RDY !== 1'b1 || INFERED_DIGIT !== 8'd5) begin
      fails++;
      $display("[TB] FAIL rst_result: rdy=%b digit=%h, required 1/05", COPROCESSOR_RDY, INFERED_DIGIT);
    end
    NEW_IMAGE = 1'b0;
    step();
    step();
  endtask

`ifdef SNN_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bit ok;
    for (int run = 0; run < 2; run++) begin
      NEW_IMAGE = 1'b1;
      step();
      checks++;
      if (TIMEOUT !== 1'b0) begin
        fails++;
        $display("[TB] FAIL to_clear_on_start run %0d: to=%b, required 0", run, TIMEOUT);
      end
      wait_start(400, 1'b0, n, ok);
      checks++;
      if (!ok) begin
        fails++;
        $display("[TB] FAIL to_start run %0d: not seen in %0d cycles, required start", run, n);
      end
      for (int c = 0; c < 16; c++) step();
      checks++;
      if (COPROCESSOR_RDY !== 1'b0) begin
        fails++;
        $display("[TB] FAIL to_run16 run %0d: rdy=%b, required 0", run, COPROCESSOR_RDY);
      end
      if (run == 1) begin
        CORE_DONE  = 1'b1;
        CORE_DIGIT = 8'h21;
      end
      step();
      CORE_DONE  = 1'b0;
      CORE_DIGIT = 8'h00;
      checks++;
      if (run == 0 && (COPROCESSOR_RDY !== 1'b1 || INFERED_DIGIT !== 8'hFF || TIMEOUT !== 1'b1)) begin
        fails++;
        $display("[TB] FAIL to_expire: rdy=%b digit=%h to=%b, required 1/FF/1",
                 COPROCESSOR_RDY, INFERED_DIGIT, TIMEOUT);
      end
      if (run == 1 && (COPROCESSOR_RDY !== 1'b1 || INFERED_DIGIT !== 8'h21 || TIMEOUT !== 1'b0)) begin
        fails++;
        $display("[TB] FAIL to_done_wins: rdy=%b digit=%h to=%b, required 1/21/0",
                 COPROCESSOR_RDY, INFERED_DIGIT, TIMEOUT);
      end
      NEW_IMAGE = 1'b0;
      step();
      step();
    end
  endtask
`endif

  initial begin
    load_image(0);
    $display("[TB] starting snn_inference_ctrl bench");
    test_reset();
    test_basic();
    test_backpressure();
    test_drop_and_spurious();
    test_reset_mid_load();
`ifdef SNN_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
